// File: rtl/ysyx_22041211_dmem_resp_if.sv
// ysyx_22041211_dmem_resp_if: request/response bus between the memory stage and the data memory
interface ysyx_22041211_dmem_resp_if #(
    parameter int DATA_LEN = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [DATA_LEN-1:0]   req_addr;
    logic [DATA_LEN-1:0]   req_wdata;
    logic [DATA_LEN/8-1:0] req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_LEN-1:0]   rsp_rdata;
    logic                  rsp_err;
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22041211_dmem_resp.sv
// ysyx_22041211_dmem_resp: latency-bearing word memory slave with valid/ready request and response
module ysyx_22041211_dmem_resp #(
    parameter int                  DATA_LEN   = 32,
    parameter int                  DEPTH_LOG2 = 10,
    parameter logic [DATA_LEN-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                  LATENCY    = 2
) (
    input logic                         clk,
    input logic                         rst,
    ysyx_22041211_dmem_resp_if.slave    bus
);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int NB = DATA_LEN / 8;
    localparam logic [DATA_LEN-1:0] SPAN = DATA_LEN'(4) << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                wen_q;
    logic [DATA_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [NB-1:0]       wstrb_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                err_q;
    logic [DATA_LEN-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic                  accept;
    logic                  enter_resp;
    logic                  acc_wen;
    logic                  in_range;
    logic [DATA_LEN-1:0]   acc_addr;
    logic [DATA_LEN-1:0]   acc_wdata;
    logic [DATA_LEN-1:0]   offset;
    logic [NB-1:0]         acc_wstrb;
    logic [DEPTH_LOG2-1:0] idx;

    // With zero latency the access happens on the accept edge, so take the live request fields then
    always_comb begin
        accept     = state == IDLE && bus.req_valid && !rst;
        enter_resp = !rst && (state == BUSY ? cnt == CW'(1) : accept && LATENCY == 0);
        acc_wen    = state == IDLE ? bus.req_wen   : wen_q;
        acc_addr   = state == IDLE ? bus.req_addr  : addr_q;
        acc_wdata  = state == IDLE ? bus.req_wdata : wdata_q;
        acc_wstrb  = state == IDLE ? bus.req_wstrb : wstrb_q;
        offset     = acc_addr - BASE_ADDR;
        in_range   = offset < SPAN;
        idx        = offset[DEPTH_LOG2+1:2];
    end

    assign bus.req_ready = state == IDLE && !rst;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Transaction sequencing: latch on accept, count down the latency, hold the response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    wen_q   <= bus.req_wen;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    wstrb_q <= bus.req_wstrb;
                    cnt     <= CW'(LATENCY);
                    state   <= LATENCY > 0 ? BUSY : RESP;
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rdata_q <= (!acc_wen && in_range) ? mem[idx] : '0;
                err_q   <= !in_range;
            end
        end
    end

    // Storage is never reset; lanes with a clear strobe keep their old bytes
    always_ff @(posedge clk)
        if (enter_resp && acc_wen && in_range)
            for (int b = 0; b < NB; b++)
                if (acc_wstrb[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
endmodule

// File: tb/tb_ysyx_22041211_dmem_resp.sv
// tb_ysyx_22041211_dmem_resp: directed and random checks of two responders (latency 2 and 0)
module tb_ysyx_22041211_dmem_resp;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22041211_dmem_resp_if b0 ();
    ysyx_22041211_dmem_resp_if b1 ();

    ysyx_22041211_dmem_resp #(.LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    ysyx_22041211_dmem_resp #(.LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    logic        rv [2];
    logic        wn [2];
    logic        rr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  ws [2];
    logic        rdy [2];
    logic        vl [2];
    logic        er [2];
    logic [31:0] rd [2];

    assign b0.req_valid = rv[0];
    assign b0.req_wen   = wn[0];
    assign b0.req_addr  = ad[0];
    assign b0.req_wdata = wd[0];
    assign b0.req_wstrb = ws[0];
    assign b0.rsp_ready = rr[0];
    assign b1.req_valid = rv[1];
    assign b1.req_wen   = wn[1];
    assign b1.req_addr  = ad[1];
    assign b1.req_wdata = wd[1];
    assign b1.req_wstrb = ws[1];
    assign b1.rsp_ready = rr[1];
    assign rdy[0] = b0.req_ready;
    assign vl[0]  = b0.rsp_valid;
    assign er[0]  = b0.rsp_err;
    assign rd[0]  = b0.rsp_rdata;
    assign rdy[1] = b1.req_ready;
    assign vl[1]  = b1.rsp_valid;
    assign er[1]  = b1.rsp_err;
    assign rd[1]  = b1.rsp_rdata;

    int ncmp = 0;
    int nerr = 0;

    // Reference memory: one word and a byte-known mask per (responder, word index)
    logic [31:0] mdat [int];
    logic [3:0]  mknown [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                       input logic [3:0] s, input int hold, output logic [31:0] r, output logic e,
                       output int lat, output logic ok);
        int n;
        n = 0; ok = 1'b0; r = '0; e = 1'b0; lat = 0;
        rv[d] = 1'b1; wn[d] = w; ad[d] = a; wd[d] = dat; ws[d] = s; rr[d] = (hold == 0);
        while (!rdy[d] && n < 50) begin @(posedge clk); #1; n++; end
        if (!rdy[d]) begin rv[d] = 1'b0; return; end
        @(posedge clk); #1;
        rv[d] = 1'b0; wn[d] = 1'($urandom); ad[d] = $urandom; wd[d] = $urandom; ws[d] = 4'($urandom);
        while (!vl[d] && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!vl[d]) return;
        r = rd[d]; e = er[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(vl[d]), 32'd1);
            chk("hold_rdata", rd[d], r);
        end
        rr[d] = 1'b1;
        @(posedge clk); #1;
        ok = 1'b1;
    endtask

    task automatic op(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input int hold, output logic [31:0] r);
        logic [31:0] off, exp, km, tmp, lm;
        logic        e, ok, inr;
        int          lat, key;
        txn(d, w, a, dat, s, hold, r, e, lat, ok);
        chk("no_timeout", 32'(ok), 32'd1);
        if (!ok) return;
        off = a - BASE;
        inr = off < 32'h1000;
        key = d * 1024 + int'(off[11:2]);
        chk("latency", 32'(lat), d == 0 ? 32'd2 : 32'd0);
        chk("err", 32'(e), 32'(!inr));
        exp = '0; km = '1;
        if (inr && !w) begin
            exp = mdat.exists(key) ? mdat[key] : '0;
            km = '0;
            for (int i = 0; i < 4; i++)
                if (mknown.exists(key) && mknown[key][i]) km = km | (32'hFF << (8 * i));
        end
        chk("rdata", r & km, exp & km);
        if (inr && w) begin
            if (!mdat.exists(key)) begin mdat[key] = '0; mknown[key] = '0; end
            tmp = mdat[key];
            for (int i = 0; i < 4; i++)
                if (s[i]) begin
                    lm = 32'hFF << (8 * i);
                    tmp = (tmp & ~lm) | (dat & lm);
                    mknown[key][i] = 1'b1;
                end
            mdat[key] = tmp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a;
        int          n;
        time         t0;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; wn[d] = 0; rr[d] = 1; ad[d] = '0; wd[d] = '0; ws[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(rdy[d]), 32'd0);
            chk("rst_valid", 32'(vl[d]), 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
            chk("rst_err", 32'(er[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("ready_after_rst", 32'(rdy[d]), 32'd1);

        op(0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, r);
        chk("wr_rdata_zero", r, 32'd0);
        op(0, 0, BASE + 32'h10, 32'd0, 4'h0, 0, r);
        chk("rd_full", r, 32'hDEADBEEF);
        op(0, 1, BASE + 32'h10, 32'h0000_5A00, 4'b0010, 0, r);
        op(0, 0, BASE + 32'h10, 32'd0, 4'h0, 0, r);
        chk("rd_lane1", r, 32'hDEAD5AEF);
        op(0, 1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, r);
        op(0, 0, BASE + 32'h13, 32'd0, 4'h0, 0, r);
        chk("rd_nostrb_unaligned", r, 32'hDEAD5AEF);
        op(0, 1, BASE, 32'h1234_5678, 4'hF, 0, r);
        op(0, 0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0, r);
        chk("rd_below", r, 32'd0);
        op(0, 0, BASE + 32'h1000, 32'd0, 4'h0, 0, r);
        chk("rd_above", r, 32'd0);
        op(0, 1, BASE + 32'h1000, 32'hCAFE_F00D, 4'hF, 0, r);
        op(0, 0, BASE, 32'd0, 4'h0, 0, r);
        chk("word0_kept", r, 32'h1234_5678);
        op(0, 1, BASE + 32'hFFC, 32'h0F1E_2D3C, 4'hF, 0, r);
        op(0, 0, BASE + 32'hFFC, 32'd0, 4'h0, 0, r);
        chk("last_word", r, 32'h0F1E_2D3C);

        rv[0] = 1; wn[0] = 0; ad[0] = BASE + 32'h10; rr[0] = 0;
        @(posedge clk); #1;
        wn[0] = 1; wd[0] = 32'h1111_1111; ws[0] = 4'hF;
        n = 0;
        while (!vl[0] && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_latency", 32'(n), 32'd2);
        r = rd[0];
        chk("bp_rdata", r, 32'hDEAD5AEF);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(vl[0]), 32'd1);
            chk("bp_stable", rd[0], r);
            chk("bp_ready_low", 32'(rdy[0]), 32'd0);
        end
        rr[0] = 1;
        @(posedge clk); #1;
        chk("bp_ready_back", 32'(rdy[0]), 32'd1);
        chk("bp_valid_drop", 32'(vl[0]), 32'd0);
        rv[0] = 0;
        op(0, 0, BASE + 32'h10, 32'd0, 4'h0, 0, r);
        chk("bp_ignored_write", r, 32'hDEAD5AEF);

        op(0, 1, BASE + 32'h20, 32'hA5A5_0F0F, 4'hF, 0, r);
        rv[0] = 1; wn[0] = 1; ad[0] = BASE + 32'h20; wd[0] = 32'h0102_0304; ws[0] = 4'hF; rr[0] = 1;
        @(posedge clk); #1;
        rv[0] = 0;
        chk("busy_ready", 32'(rdy[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_ready", 32'(rdy[d]), 32'd0);
            chk("midrst_valid", 32'(vl[d]), 32'd0);
            chk("midrst_rdata", rd[d], 32'd0);
            chk("midrst_err", 32'(er[d]), 32'd0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("dropped_no_rsp", 32'(vl[0]), 32'd0);
        end
        op(0, 0, BASE + 32'h20, 32'd0, 4'h0, 0, r);
        chk("dropped_no_write", r, 32'hA5A5_0F0F);

        op(1, 1, BASE + 32'h40, 32'h0BAD_CAFE, 4'hF, 0, r);
        t0 = $time;
        repeat (5) begin
            op(1, 0, BASE + 32'h40, 32'd0, 4'h0, 0, r);
            chk("lat0_rdata", r, 32'h0BAD_CAFE);
        end
        chk("lat0_throughput", 32'(($time - t0) / 10), 32'd10);
        t0 = $time;
        repeat (4) op(0, 0, BASE + 32'h40, 32'd0, 4'h0, 0, r);
        chk("lat2_throughput", 32'(($time - t0) / 10), 32'd16);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) op(d, 1, BASE + 32'(4 * i), $urandom, 4'hF, 0, r);
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 9))
                0: a = 32'h7FFF_FFFC - 32'($urandom_range(0, 64));
                1: a = BASE + 32'h1000 + 32'($urandom_range(0, 64));
                2: a = BASE + 32'hFFC + 32'($urandom_range(0, 3));
                3: a = $urandom;
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            op($urandom_range(0, 1), 1'($urandom), a, $urandom, 4'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
